// File: rtl/exp_irq_controller_pkg.sv
// Shared types and constants for the external exception sequencer feeding CP0.
package exp_irq_controller_pkg;

  localparam int unsigned DefNumSrc = 3;
  localparam int unsigned DefCauseW = 2;

  // Cause codes as seen in the CP0 cause field.
  localparam logic [DefCauseW-1:0] EXC_SRC0 = 2'd0;
  localparam logic [DefCauseW-1:0] EXC_SRC1 = 2'd1;
  localparam logic [DefCauseW-1:0] EXC_SRC2 = 2'd2;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StService
  } exp_state_e;

  function automatic logic [DefCauseW-1:0] src_cause(input int unsigned idx);
    unique case (idx)
      0:       src_cause = EXC_SRC0;
      1:       src_cause = EXC_SRC1;
      default: src_cause = EXC_SRC2;
    endcase
  endfunction

endpackage

// File: rtl/exp_irq_controller_if.sv
// Bundle between the exception controller and its CPU/CP0 side.
interface exp_irq_controller_if #(
  parameter int unsigned NUM_SRC = 3,
  parameter int unsigned CAUSE_W = 2
);
  logic [NUM_SRC-1:0] exp_src;
  logic               exp_block;
  logic               mask_we;
  logic [NUM_SRC-1:0] mask_wdata;
  logic               exp_ack;
  logic               eret;
  logic               exp_req;
  logic [CAUSE_W-1:0] exp_cause;
  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] mask;
  logic [NUM_SRC-1:0] lost;
  logic               in_service;

  modport master (
    output exp_src, exp_block, mask_we, mask_wdata, exp_ack, eret,
    input  exp_req, exp_cause, pending, mask, lost, in_service
  );

  modport slave (
    input  exp_src, exp_block, mask_we, mask_wdata, exp_ack, eret,
    output exp_req, exp_cause, pending, mask, lost, in_service
  );
endinterface

// File: rtl/exp_src_sync.sv
// Per-source synchroniser chain followed by a rising-edge detector.
module exp_src_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic src_i,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], src_i};
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/exp_irq_controller.sv
// Latches synchronised exception edges, arbitrates by fixed priority and
// serialises one request at a time into CP0 until ERET.
module exp_irq_controller
  import exp_irq_controller_pkg::*;
#(
  parameter int unsigned        NUM_SRC     = DefNumSrc,
  parameter int unsigned        CAUSE_W     = DefCauseW,
  parameter int unsigned        SYNC_STAGES = 2,
  parameter logic [NUM_SRC-1:0] MASK_RST    = {NUM_SRC{1'b1}}
) (
  input logic                clk,
  input logic                rst,
  exp_irq_controller_if.slave bus
);

  exp_state_e         state_q;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] lost_q, lost_d;
  logic [NUM_SRC-1:0] mask_q;
  logic [CAUSE_W-1:0] cause_q;
  logic               req_q;
  logic               in_service_q;

  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] eligible;
  logic [NUM_SRC-1:0] clr;
  logic [CAUSE_W-1:0] win_cause;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_sync
    exp_src_sync #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
      .clk_i (clk),
      .rst_ni(rst),
      .src_i (bus.exp_src[g]),
      .rise_o(rise[g])
    );
  end

  assign eligible = pending_q & mask_q;

  // Descending scan so the lowest eligible index is the last one written.
  always_comb begin
    win_cause = '0;
    for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
      if (eligible[i]) win_cause = CAUSE_W'(src_cause(unsigned'(i)));
    end
  end

  // A fresh edge on the source being acknowledged keeps it pending (set wins).
  always_comb begin
    clr = '0;
    if (state_q == StReq && bus.exp_ack) clr = NUM_SRC'(1) << cause_q;
    pending_d = (pending_q & ~clr) | rise;
    lost_d    = lost_q | (rise & pending_q & ~clr);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= StIdle;
      pending_q    <= '0;
      lost_q       <= '0;
      mask_q       <= MASK_RST;
      cause_q      <= CAUSE_W'(EXC_SRC0);
      req_q        <= 1'b0;
      in_service_q <= 1'b0;
    end else begin
      pending_q <= pending_d;
      lost_q    <= lost_d;
      if (bus.mask_we) mask_q <= bus.mask_wdata;
      unique case (state_q)
        StIdle: begin
          if (|eligible && !bus.exp_block) begin
            cause_q <= win_cause;
            req_q   <= 1'b1;
            state_q <= StReq;
          end
        end
        StReq: begin
          if (bus.exp_ack) begin
            req_q        <= 1'b0;
            in_service_q <= 1'b1;
            state_q      <= StService;
          end
        end
        StService: begin
          if (bus.eret) begin
            in_service_q <= 1'b0;
            state_q      <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.exp_req    = req_q;
  assign bus.exp_cause  = cause_q;
  assign bus.pending    = pending_q;
  assign bus.mask       = mask_q;
  assign bus.lost       = lost_q;
  assign bus.in_service = in_service_q;

endmodule

// File: tb/tb_exp_irq_controller.sv
// Scoreboard bench: a sample-history reference model predicts every cycle,
// a separate monitor compares the DUT after each clock edge.
module tb_exp_irq_controller;
  import exp_irq_controller_pkg::*;

  localparam int unsigned N  = 3;
  localparam int unsigned CW = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  exp_irq_controller_if #(.NUM_SRC(N), .CAUSE_W(CW)) bus ();

  exp_irq_controller #(
    .NUM_SRC    (N),
    .CAUSE_W    (CW),
    .SYNC_STAGES(2),
    .MASK_RST   (3'b111)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic       req;
    logic [1:0] cause;
    logic [2:0] pend;
    logic [2:0] lost;
    logic [2:0] mask;
    logic       insvc;
  } snap_t;

  snap_t sb_q[$];
  int    checks = 0;
  int    errors = 0;

  // Reference model: samp[k] = exp_src captured k+1 edges ago (0 while in reset).
  logic [2:0] samp[3];
  logic [2:0] m_pend, m_lost, m_mask;
  logic [1:0] m_cause;
  int         m_phase;  // 0 waiting, 1 requesting, 2 handler running
  logic [1:0] cause_tab[3];

  task automatic model_edge(input bit r, input bit [2:0] src, input bit blk, input bit mwe,
                            input bit [2:0] mwd, input bit ack, input bit er);
    logic [2:0] np, nl, rise;
    int         ph;
    int         win;
    if (!r) begin
      for (int k = 0; k < 3; k++) samp[k] = 3'b000;
      m_pend = '0; m_lost = '0; m_mask = 3'b111; m_cause = '0; m_phase = 0;
      return;
    end
    // Edge seen now if the sample two edges back was high and three back was low.
    rise = samp[1] & ~samp[2];
    np = m_pend;
    nl = m_lost;
    for (int i = 0; i < 3; i++) begin
      bit acked;
      acked = (m_phase == 1) && ack && (m_cause == cause_tab[i]);
      if (rise[i]) begin
        if (m_pend[i] && !acked) nl[i] = 1'b1;
        np[i] = 1'b1;
      end else if (acked) begin
        np[i] = 1'b0;
      end
    end
    ph = m_phase;
    if (m_phase == 0) begin
      win = -1;
      for (int i = 2; i >= 0; i--) if (m_pend[i] && m_mask[i]) win = i;
      if (win >= 0 && !blk) begin
        m_cause = cause_tab[win];
        ph = 1;
      end
    end else if (m_phase == 1) begin
      if (ack) ph = 2;
    end else begin
      if (er) ph = 0;
    end
    if (mwe) m_mask = mwd;
    samp[2] = samp[1];
    samp[1] = samp[0];
    samp[0] = src;
    m_pend = np;
    m_lost = nl;
    m_phase = ph;
  endtask

  task automatic cyc(input bit r, input bit [2:0] src, input bit blk, input bit mwe,
                     input bit [2:0] mwd, input bit ack, input bit er);
    snap_t s;
    @(negedge clk);
    rst            = r;
    bus.exp_src    = src;
    bus.exp_block  = blk;
    bus.mask_we    = mwe;
    bus.mask_wdata = mwd;
    bus.exp_ack    = ack;
    bus.eret       = er;
    model_edge(r, src, blk, mwe, mwd, ack, er);
    s.req   = (m_phase == 1);
    s.cause = m_cause;
    s.pend  = m_pend;
    s.lost  = m_lost;
    s.mask  = m_mask;
    s.insvc = (m_phase == 2);
    @(posedge clk);
    sb_q.push_back(s);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  initial begin : monitor
    snap_t s;
    forever begin
      @(negedge clk);
      while (sb_q.size() > 0) begin
        s = sb_q.pop_front();
        chk("exp_req", 32'(bus.exp_req), 32'(s.req));
        if (s.req) chk("exp_cause", 32'(bus.exp_cause), 32'(s.cause));
        chk("pending", 32'(bus.pending), 32'(s.pend));
        chk("lost", 32'(bus.lost), 32'(s.lost));
        chk("mask", 32'(bus.mask), 32'(s.mask));
        chk("in_service", 32'(bus.in_service), 32'(s.insvc));
      end
    end
  end

  task automatic idle(input int n, input bit [2:0] src);
    for (int k = 0; k < n; k++) cyc(1, src, 0, 0, 3'b000, 0, 0);
  endtask

  task automatic ack_eret();
    cyc(1, 3'b000, 0, 0, 3'b000, 1, 0);
    cyc(1, 3'b000, 0, 0, 3'b000, 0, 0);
    cyc(1, 3'b000, 0, 0, 3'b000, 0, 1);
  endtask

  initial begin : stimulus
    logic [2:0] src;
    bit         r;
    cause_tab[0] = EXC_SRC0;
    cause_tab[1] = EXC_SRC1;
    cause_tab[2] = EXC_SRC2;
    bus.exp_src = '0; bus.exp_block = 0; bus.mask_we = 0; bus.mask_wdata = '0;
    bus.exp_ack = 0; bus.eret = 0;

    // Reset with all sources high, then release and drain the three events.
    cyc(0, 3'b111, 0, 0, 3'b000, 0, 0);
    cyc(0, 3'b111, 0, 0, 3'b000, 0, 0);
    idle(4, 3'b111);
    idle(2, 3'b000);
    for (int k = 0; k < 3; k++) begin
      ack_eret();
      idle(1, 3'b000);
    end
    // Single request from source 1.
    idle(2, 3'b010); idle(4, 3'b000); ack_eret(); idle(2, 3'b000);
    // Sources 2 and 0 together: 0 first, 2 right after ERET.
    idle(2, 3'b101); idle(4, 3'b000); ack_eret(); idle(2, 3'b000); ack_eret(); idle(1, 3'b000);
    // Masked source 0 stays pending until the mask reopens.
    cyc(1, 3'b000, 0, 1, 3'b110, 0, 0);
    idle(2, 3'b001); idle(5, 3'b000);
    cyc(1, 3'b000, 0, 1, 3'b111, 0, 0);
    idle(2, 3'b000); ack_eret(); idle(1, 3'b000);
    // Two pulses before ack sets lost[1].
    idle(2, 3'b010); idle(2, 3'b000); idle(2, 3'b010); idle(3, 3'b000); ack_eret();
    idle(2, 3'b000); ack_eret(); idle(2, 3'b000);
    // Edge on source 1 coincides with ack of cause 1.
    idle(2, 3'b010); idle(2, 3'b000); idle(2, 3'b010);
    cyc(1, 3'b000, 0, 0, 3'b000, 1, 0);
    cyc(1, 3'b000, 0, 0, 3'b000, 0, 1); idle(2, 3'b000); ack_eret(); idle(2, 3'b000);
    // Block holds off a pending request.
    idle(2, 3'b001);
    for (int k = 0; k < 5; k++) cyc(1, 3'b000, 1, 0, 3'b000, 0, 0);
    idle(2, 3'b000); ack_eret(); idle(1, 3'b000);
    // Reset during service, then a stray ERET.
    idle(2, 3'b100); idle(4, 3'b000);
    cyc(1, 3'b000, 0, 0, 3'b000, 1, 0);
    cyc(0, 3'b000, 0, 0, 3'b000, 0, 0);
    cyc(1, 3'b000, 0, 0, 3'b000, 0, 1);
    idle(3, 3'b000);

    // Randomised traffic.
    src = '0;
    for (int k = 0; k < 3000; k++) begin
      for (int b = 0; b < 3; b++) if ($urandom_range(3) == 0) src[b] = ~src[b];
      r = ($urandom_range(299) != 0);
      cyc(r, src, ($urandom_range(7) == 0), ($urandom_range(15) == 0), 3'($urandom),
          ($urandom_range(2) == 0), ($urandom_range(3) == 0));
    end

    @(negedge clk);
    @(negedge clk);
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
